// File: rtl/inst_defs_pkg.sv
// Shared RV32I fetch definitions: widths, the canonical NOP, reset PC and the
// entry format held in the fetch buffer.
package inst_defs_pkg;

    localparam int                XLEN      = 32;
    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]   RESET_PC  = '0;
    localparam int                BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries between the memory
// response and decode. Flush has priority over push.
module fetch_buffer
    import inst_defs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observed after being written.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, drives the synchronous imem and
// hands {instr, pc, pc+4} to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int                XLEN      = inst_defs_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC  = inst_defs_pkg::RESET_PC,
    parameter int                BUF_DEPTH = inst_defs_pkg::BUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    import inst_defs_pkg::*;

    logic [XLEN-1:0] r_pc_q;
    logic            r_inflight;
    logic [XLEN-1:0] r_if_pc;
    logic            r_if_epoch;
    logic            r_epoch;

    logic [XLEN-1:0] w_redir_addr;
    logic            w_resp_ok;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occ;
    logic            w_buf_full;
    logic            w_buf_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_resp;

    fetch_buffer #(
        .DEPTH   (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_resp),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_redir_addr = word_align(redirect_pc);
        // A response landing in a redirect cycle is wrong-path even if its epoch still matches.
        w_resp_ok    = r_inflight & (r_if_epoch == r_epoch) & ~redirect_valid;
        w_resp.instr = imem_rdata;
        w_resp.pc    = r_if_pc;

        if_valid = ~redirect_valid & (~w_buf_empty | w_resp_ok);
        if_instr = NOP_INSTR;
        if_pc    = '0;
        if (!w_buf_empty) begin
            if_instr = w_head.instr;
            if_pc    = w_head.pc;
        end else if (w_resp_ok) begin
            if_instr = imem_rdata;
            if_pc    = r_if_pc;
        end
        if_pc_plus4 = if_pc + XLEN'(4);

        w_pop  = if_valid & id_ready;
        w_push = w_resp_ok & ~(w_buf_empty & w_pop);

        // Only issue when the response is guaranteed a free slot next cycle.
        w_occ   = w_buf_full ? 3'(BUF_DEPTH) : (w_buf_empty ? 3'd0 : 3'd1);
        w_issue = (w_occ + {2'b00, r_inflight}) < (3'(BUF_DEPTH) + {2'b00, w_pop});

        imem_req  = ~rst & (redirect_valid | w_issue);
        imem_addr = rst ? RESET_PC : (redirect_valid ? w_redir_addr : r_pc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_q     <= RESET_PC;
            r_inflight <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_epoch <= 1'b0;
            r_epoch    <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_if_pc    <= imem_addr;
                r_if_epoch <= redirect_valid ? ~r_epoch : r_epoch;
                r_pc_q     <= imem_addr + XLEN'(4);
            end
            if (redirect_valid) r_epoch <= ~r_epoch;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 1-cycle imem model plus a scoreboard of the PCs
// decode must accept, in order, with instr and pc+4 derived from each PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic score();
        logic [31:0] e;
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_accept", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("if_pc", if_pc, e);
                chk("if_instr", if_instr, mem_word(e));
                chk("if_pc_plus4", if_pc_plus4, e + 32'd4);
            end
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        score();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        wait_neg();
        to_pos();
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(i * 4));
    endtask

    task automatic drain(input int budget);
        id_ready = 1'b1;
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        id_ready = 1'b0;
        chk("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd4);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int reqcnt;

        // Reset values, then first fetch and first delivery.
        wait_neg();
        chk_reset_outputs("rst");
        to_pos();
        rst = 1'b0;
        id_ready = 1'b1;
        push_seq(32'h0, 2);
        wait_neg();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid_c0", {31'd0, if_valid}, 32'd0);
        to_pos();
        wait_neg();
        chk("first_valid_c1", {31'd0, if_valid}, 32'd1);
        to_pos();
        drain(20);

        // Stall at pc 8 for five cycles.
        reqcnt = 0;
        for (int i = 0; i < 5; i++) begin
            wait_neg();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_instr", if_instr, mem_word(32'h8));
            reqcnt += int'(imem_req);
            if (i == 4) chk("stall_req_off", {31'd0, imem_req}, 32'd0);
            to_pos();
        end
        chk("stall_req_bound", {31'd0, reqcnt <= 2}, 32'd1);
        push_seq(32'h8, 4);
        drain(20);

        // Redirect while the buffer is full.
        tick();
        tick();
        tick();
        push_seq(32'h100, 3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        id_ready = 1'b1;
        wait_neg();
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid_low", {31'd0, if_valid}, 32'd0);
        to_pos();
        redirect_valid = 1'b0;
        drain(20);

        // Misaligned redirect during a stall.
        tick();
        tick();
        push_seq(32'h200, 2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        wait_neg();
        chk("misalign_addr", imem_addr, 32'h200);
        chk("misalign_req", {31'd0, imem_req}, 32'd1);
        chk("misalign_valid_low", {31'd0, if_valid}, 32'd0);
        to_pos();
        redirect_valid = 1'b0;
        wait_neg();
        chk("misalign_valid", {31'd0, if_valid}, 32'd1);
        chk("misalign_pc", if_pc, 32'h200);
        to_pos();
        drain(20);

        // Back-to-back redirects: the last target wins.
        push_seq(32'h80, 3);
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        wait_neg();
        chk("b2b_addr_0", imem_addr, 32'h40);
        to_pos();
        redirect_pc = 32'h80;
        wait_neg();
        chk("b2b_addr_1", imem_addr, 32'h80);
        chk("b2b_valid_low", {31'd0, if_valid}, 32'd0);
        to_pos();
        redirect_valid = 1'b0;
        drain(20);

        // PC wrap at the top of the address space.
        push_seq(32'hFFFF_FFF8, 4);
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        to_pos();
        redirect_valid = 1'b0;
        drain(20);

        // Reset mid-stream with a response pending.
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        tick();
        tick();
        rst = 1'b0;
        push_seq(32'h0, 3);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
